aes_dec_loader: RTL and testbench

//  Word-serial front/back end for the iterative AES inverse-cipher core (Decrypt).

---
 rtl/aes_dec_loader.sv | 123 ++++++++++++
 tb/tb_aes_dec_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_loader.sv
// Word-serial front/back end for an iterative AES inverse-cipher core:
// streams in key + ciphertext, runs the core for NR+1 clocks, streams out plaintext.
module aes_dec_loader #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             keep_key,
  output logic [NK*32-1:0] dec_key,
  output logic [127:0]     dec_state,
  output logic             dec_enable,
  input  logic [127:0]     dec_out,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int WCW = $clog2(NK);
  localparam int RCW = $clog2(NR + 1);
  localparam logic [WCW-1:0] KEY_LAST = WCW'(NK - 1);
  localparam logic [WCW-1:0] BLK_LAST = WCW'(3);
  localparam logic [RCW-1:0] RUN_LAST = RCW'(NR);

  localparam logic [2:0] S_LOAD_KEY = 3'd0;
  localparam logic [2:0] S_LOAD_CT  = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  logic [2:0]           state;
  logic [WCW-1:0]       word_cnt;
  logic [RCW-1:0]       run_cnt;
  logic [NK-1:0][31:0]  key_q;
  logic [3:0][31:0]     ct_q;
  logic [3:0][31:0]     result;
  logic                 in_fire;
  logic                 out_fire;

  assign in_ready  = (state == S_LOAD_KEY) || (state == S_LOAD_CT);
  assign busy      = !(in_ready && (word_cnt == '0));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign dec_key   = key_q;
  assign dec_state = ct_q;
  // Word 0 is the most-significant word; ~cnt maps 0..3 onto lanes 3..0.
  assign out_data  = result[~word_cnt[1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD_KEY;
      word_cnt   <= '0;
      run_cnt    <= '0;
      key_q      <= '0;
      ct_q       <= '0;
      result     <= '0;
      dec_enable <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        S_LOAD_KEY: begin
          if (in_fire) begin
            key_q[KEY_LAST - word_cnt] <= in_data;
            if (word_cnt == KEY_LAST) begin
              word_cnt <= '0;
              state    <= S_LOAD_CT;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_LOAD_CT: begin
          if (in_fire) begin
            ct_q[~word_cnt[1:0]] <= in_data;
            if (word_cnt == BLK_LAST) begin
              word_cnt   <= '0;
              run_cnt    <= '0;
              dec_enable <= 1'b1;
              state      <= S_RUN;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (run_cnt == RUN_LAST) begin
            dec_enable <= 1'b0;
            state      <= S_WAIT;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // Core output has settled one clock after the last enabled round.
          result    <= dec_out;
          out_valid <= 1'b1;
          word_cnt  <= '0;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_fire) begin
            if (word_cnt == BLK_LAST) begin
              word_cnt  <= '0;
              out_valid <= 1'b0;
              state     <= keep_key ? S_LOAD_CT : S_LOAD_KEY;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: begin
          state      <= S_LOAD_KEY;
          word_cnt   <= '0;
          dec_enable <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_dec_loader.sv
// Bench for aes_dec_loader: NK=4/NR=10 and NK=8/NR=14 instances, each driving a
// mock core whose output is only correct after exactly NR+1 consecutive enabled clocks.
module tb_aes_dec_loader;
  localparam int NK4 = 4, NR4 = 10, NK8 = 8, NR8 = 14;
  localparam logic [127:0] C1_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [255:0] C3_KEY = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca_516745bf_eafc4990_4b496089;
  localparam logic [127:0] PT     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] JUNK   = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  typedef struct {
    logic [127:0] key, ct, pt;
    int vprob, oprob, stall;
    bit keep, garbage, rst_mid;
  } vec_t;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  // NK=4 instance
  logic [31:0] in_data = 0, out_data;
  logic in_valid = 0, in_ready, keep_key = 0, dec_enable, out_valid, out_ready = 0, busy;
  logic [127:0] dec_key, dec_state, dec_out;
  // NK=8 instance
  logic [31:0] in_data8 = 0, out_data8;
  logic in_valid8 = 0, in_ready8, dec_enable8, out_valid8, out_ready8 = 0, busy8;
  logic [255:0] dec_key8;
  logic [127:0] dec_state8, dec_out8;

  aes_dec_loader #(.NK(NK4), .NR(NR4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .keep_key(keep_key), .dec_key(dec_key), .dec_state(dec_state), .dec_enable(dec_enable),
    .dec_out(dec_out), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy));

  aes_dec_loader #(.NK(NK8), .NR(NR8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .keep_key(1'b0), .dec_key(dec_key8), .dec_state(dec_state8), .dec_enable(dec_enable8),
    .dec_out(dec_out8), .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .busy(busy8));

  // Known FIPS-197 vectors decrypt to PT; anything else gets a cheap keyed scramble.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] c);
    if (k == {128'h0, C1_KEY} && c == C1_CT) return PT;
    if (k == C3_KEY && c == C3_CT) return PT;
    return {c[95:0], c[127:96]} ^ k[127:0] ^ k[255:128] ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  endfunction

  int run_len4 = 0, run_len8 = 0;
  logic en_prev4 = 0, en_prev8 = 0;
  always @(posedge clk) begin
    if (dec_enable) run_len4 <= en_prev4 ? run_len4 + 1 : 1;
    en_prev4 <= dec_enable;
    if (dec_enable8) run_len8 <= en_prev8 ? run_len8 + 1 : 1;
    en_prev8 <= dec_enable8;
  end
  assign dec_out  = (run_len4 == NR4 + 1 && !dec_enable) ? core_fn({128'h0, dec_key}, dec_state) : JUNK;
  assign dec_out8 = (run_len8 == NR8 + 1 && !dec_enable8) ? core_fn(dec_key8, dec_state8) : JUNK;

  int vec = 0, errs = 0;
  bit need_key = 1;
  logic [127:0] key_m = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_pulse();
    int seen;
    rst_n = 0;
    #1;
    chk("rst_enable", 256'(dec_enable), 256'(1'b0));
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_dec_key", 256'(dec_key), 256'(0));
    chk("rst_dec_state", 256'(dec_state), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    key_m = '0;
    need_key = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_partial_out", 256'(seen), 256'(0));
    chk("in_ready_after_rst", 256'(in_ready), 256'(1'b1));
  endtask

  task automatic do_block(input vec_t v);
    logic [31:0] q[$];
    int nkey, n, c, i, stall;
    nkey = need_key ? NK4 : 0;
    if (need_key) begin
      key_m = v.key;
      for (int k = 0; k < NK4; k++) q.push_back(v.key[(NK4-k)*32-1 -: 32]);
    end
    for (int k = 0; k < 4; k++) q.push_back(v.ct[(4-k)*32-1 -: 32]);
    n = 0;
    c = 0;
    while (q.size() > 0 && c < 400) begin
      @(negedge clk);
      chk("in_ready_load", 256'(in_ready), 256'(1'b1));
      chk("busy_load", 256'(busy), 256'(n != 0 && n != nkey));
      in_valid = ($urandom_range(99) < v.vprob);
      in_data = in_valid ? q[0] : $urandom();
      @(posedge clk);
      if (in_valid) begin
        void'(q.pop_front());
        n++;
      end
      c++;
    end
    chk("words_in", 256'(n), 256'(nkey + 4));
    // Core run: enable must be high for exactly NR+1 clocks, then output NR+3 clocks after last word.
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (v.rst_mid && c == 6) begin
        reset_pulse();
        return;
      end
      chk("in_ready_run", 256'(in_ready), 256'(1'b0));
      chk("enable", 256'(dec_enable), 256'(c <= NR4 + 1));
      in_valid = v.garbage ? 1'($urandom_range(1)) : 1'b0;
      in_data = $urandom();
    end while (!out_valid && c < 100);
    in_valid = 0;
    chk("latency", 256'(c), 256'(NR4 + 3));
    chk("enable_clocks", 256'(run_len4), 256'(NR4 + 1));
    chk("dec_key", 256'(dec_key), 256'(key_m));
    chk("dec_state", 256'(dec_state), 256'(v.ct));
    i = 0;
    c = 0;
    stall = v.stall;
    while (i < 4 && c < 400) begin
      chk("out_valid", 256'(out_valid), 256'(1'b1));
      chk("out_data", 256'(out_data), 256'(v.pt[(4-i)*32-1 -: 32]));
      chk("in_ready_out", 256'(in_ready), 256'(1'b0));
      out_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < v.oprob);
      if (stall > 0) stall--;
      keep_key = (i == 3) ? v.keep : !v.keep;
      @(posedge clk);
      if (out_ready) i++;
      @(negedge clk);
      c++;
    end
    out_ready = 0;
    chk("words_out", 256'(i), 256'(4));
    chk("out_valid_done", 256'(out_valid), 256'(1'b0));
    chk("in_ready_done", 256'(in_ready), 256'(1'b1));
    chk("busy_done", 256'(busy), 256'(1'b0));
    need_key = !v.keep;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    vec_t v;
    logic [255:0] k8;
    logic [127:0] c8;
    int c;
    tbl[0] = '{key:C1_KEY, ct:C1_CT, pt:PT, vprob:100, oprob:100, stall:0,  keep:0, garbage:0, rst_mid:0};
    tbl[1] = '{key:C1_KEY, ct:C1_CT, pt:PT, vprob:100, oprob:100, stall:20, keep:1, garbage:0, rst_mid:0};
    tbl[2] = '{key:C1_KEY, ct:C1_CT, pt:PT, vprob:100, oprob:100, stall:0,  keep:0, garbage:0, rst_mid:0};
    tbl[3] = '{key:C1_KEY, ct:C1_CT, pt:PT, vprob:40,  oprob:60,  stall:2,  keep:0, garbage:1, rst_mid:0};
    tbl[4] = '{key:C1_KEY, ct:C1_CT, pt:PT, vprob:100, oprob:100, stall:0,  keep:0, garbage:0, rst_mid:1};

    #12;
    chk("init_enable", 256'(dec_enable), 256'(1'b0));
    chk("init_out_valid", 256'(out_valid), 256'(1'b0));
    chk("init_out_data", 256'(out_data), 256'(0));
    chk("init_busy", 256'(busy), 256'(1'b0));
    chk("init_in_ready", 256'(in_ready), 256'(1'b1));
    chk("init_dec_key", 256'(dec_key), 256'(0));
    @(negedge clk);
    rst_n = 1;

    for (int t = 0; t < 5; t++) do_block(tbl[t]);

    for (int r = 0; r < 8; r++) begin
      v.key = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.pt  = core_fn({128'h0, need_key ? v.key : key_m}, v.ct);
      v.vprob = $urandom_range(100, 30);
      v.oprob = $urandom_range(100, 30);
      v.stall = $urandom_range(3);
      v.keep = 1'($urandom_range(1));
      v.garbage = 1'($urandom_range(1));
      v.rst_mid = 0;
      do_block(v);
    end

    // NK=8 / NR=14 instance, FIPS-197 C.3
    k8 = C3_KEY;
    c8 = C3_CT;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("in_ready8", 256'(in_ready8), 256'(1'b1));
      in_valid8 = 1;
      in_data8 = (k < 8) ? k8[(8-k)*32-1 -: 32] : c8[(12-k)*32-1 -: 32];
      @(posedge clk);
    end
    c = 0;
    do begin
      @(negedge clk);
      in_valid8 = 0;
      c++;
    end while (!out_valid8 && c < 100);
    chk("latency8", 256'(c), 256'(NR8 + 3));
    chk("enable_clocks8", 256'(run_len8), 256'(NR8 + 1));
    chk("dec_key8", dec_key8, C3_KEY);
    out_ready8 = 1;
    for (int i = 0; i < 4; i++) begin
      chk("out_valid8", 256'(out_valid8), 256'(1'b1));
      chk("out_data8", 256'(out_data8), 256'(PT[(4-i)*32-1 -: 32]));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready8 = 0;
    chk("out_valid8_done", 256'(out_valid8), 256'(1'b0));
    chk("in_ready8_done", 256'(in_ready8), 256'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
